load_store_unit: RTL and testbench

- Consumes the address produced by the ALU for STR/LDR uops and performs the data-memory access.
- Memory side is a req/ack bus; core side is a start/done pulse pair, plus a register-file writeback strobe for loads.
- Sits between the ALU output/register read ports and the data memory; the control unit stalls while busy=1.

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared uop codes, memory access sizes and LSU state encodings.
// Latency: none (declarations only).
// Backpressure: not applicable.
package load_store_unit_pkg;

    // Uop codes shared with the decoder; only STR and LDR reach the LSU.
    localparam logic [4:0] UOP_ADD = 5'h00;
    localparam logic [4:0] UOP_LDR = 5'h10;
    localparam logic [4:0] UOP_STR = 5'h11;

    // Access size as carried on the size port; encoding 3 behaves as WORD.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    // LSU sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // True when the access cannot be served by a single aligned bus beat.
    function automatic logic lsu_misaligned(input logic [1:0] sz, input logic [1:0] ofs);
        if (sz == BYTE) return 1'b0;
        if (sz == HALF) return ofs[0];
        return ofs != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: lane enables and placed store data, plus extraction of load data.
// Latency: purely combinational.
// Backpressure: none; outputs follow the inputs.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  ofs,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_pl,
    output logic [31:0] rdata_ex
);

    logic [31:0] rdata_b;
    logic [31:0] rdata_h;

    // Bring the addressed byte / halfword down to bit 0.
    always_comb begin
        rdata_b = rdata >> {ofs, 3'b000};
        rdata_h = rdata >> {ofs[1], 4'b0000};
    end

    // Lane enables, replicated store data and zero-extended load data per size.
    always_comb begin
        be       = 4'b1111;
        wdata_pl = wdata;
        rdata_ex = rdata;
        case (size)
            BYTE: begin
                be       = 4'b0001 << ofs;
                wdata_pl = {4{wdata[7:0]}};
                rdata_ex = {24'h0, rdata_b[7:0]};
            end
            HALF: begin
                be       = ofs[1] ? 4'b1100 : 4'b0011;
                wdata_pl = {2{wdata[15:0]}};
                rdata_ex = {16'h0, rdata_h[15:0]};
            end
            default: begin
                be       = 4'b1111;
                wdata_pl = wdata;
                rdata_ex = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access engine for STR/LDR over a req/ack bus; LSU_ALIGN_CHECK_EN aborts misaligned accesses.
// Latency: done 2 cycles after start at best; aborts with err after MAX_WAIT unacknowledged request cycles.
// Backpressure: busy stalls the core while the bus is outstanding; start outside IDLE and stray mem_ack are dropped.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  uop,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        rd_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic          is_load;
    logic [1:0]    size_q;
    logic [1:0]    ofs_q;

    logic          accept;
    logic [1:0]    al_size;
    logic [1:0]    al_ofs;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;

    assign accept = start && ((uop == UOP_STR) || (uop == UOP_LDR));

    // The aligner serves the incoming request while idle and the latched one afterwards.
    assign al_size = (state == ST_IDLE) ? size : size_q;
    assign al_ofs  = (state == ST_IDLE) ? addr[1:0] : ofs_q;

    lsu_lane_align u_align (
        .size     (al_size),
        .ofs      (al_ofs),
        .wdata    (wdata),
        .rdata    (mem_rdata),
        .be       (al_be),
        .wdata_pl (al_wdata),
        .rdata_ex (al_rdata)
    );

`ifdef LSU_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = lsu_misaligned(size, addr[1:0]);
`endif

    // Access sequencer: accept, hold the bus request until ack or timeout, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            is_load   <= 1'b0;
            size_q    <= 2'b00;
            ofs_q     <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            rd_we     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        is_load  <= (uop == UOP_LDR);
                        size_q   <= size;
                        ofs_q    <= addr[1:0];
                        wait_cnt <= '0;
`ifdef LSU_ALIGN_CHECK_EN
                        if (misaligned) begin
                            // Abort without touching the bus.
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else
`endif
                        begin
                            state     <= ST_REQ;
                            busy      <= 1'b1;
                            mem_req   <= 1'b1;
                            mem_we    <= (uop == UOP_STR);
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= (uop == UOP_STR) ? al_wdata : '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack || (wait_cnt == WAIT_LAST)) begin
                        // Either outcome releases the bus in the same cycle done rises.
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        err       <= !mem_ack;
                        rd_we     <= mem_ack && is_load;
                        rdata     <= (mem_ack && is_load) ? al_rdata : '0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    rd_we <= 1'b0;
                    rdata <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: transaction-level expectations for every output on every cycle, plus directed literal checks.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  uop;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err, rd_we, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    load_store_unit #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .uop(uop), .size(size), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata), .rd_we(rd_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // Expected output values for the current cycle.
    logic        e_busy, e_done, e_err, e_rd_we, e_req, e_we;
    logic [31:0] e_rdata, e_addr, e_wd;
    logic [3:0]  e_be;

    // Observations for directed checks.
    int          seen_req_cyc, seen_done_cnt, seen_done_edge;
    logic        seen_we, seen_err, seen_rd_we;
    logic [31:0] seen_addr, seen_wd, seen_rdata;
    logic [3:0]  seen_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of lane steering.
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] o);
        if (sz == 2'd0) return 4'(1 << o);
        if (sz == 2'd1) return o[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return 32'(wd[7:0]) * 32'h0101_0101;
        if (sz == 2'd1) return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic [1:0] o, input logic [31:0] rd);
        if (sz == 2'd0) return (rd >> (8 * o)) & 32'h0000_00FF;
        if (sz == 2'd1) return (rd >> (16 * o[1])) & 32'h0000_FFFF;
        return rd;
    endfunction

    function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic set_idle();
        e_busy = 0; e_done = 0; e_err = 0; e_rd_we = 0; e_req = 0; e_we = 0;
        e_rdata = 0; e_addr = 0; e_wd = 0; e_be = 0;
    endtask

    task automatic set_req(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        set_idle();
        e_busy = 1; e_req = 1; e_we = we; e_addr = a; e_be = be; e_wd = wd;
    endtask

    task automatic set_done(input logic er, input logic we, input logic [31:0] rd);
        set_idle();
        e_done = 1; e_err = er; e_rd_we = we; e_rdata = rd;
    endtask

    // One compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("err", err, e_err);
            check("rd_we", rd_we, e_rd_we);
            check("rdata", rdata, e_rdata);
            check("mem_req", mem_req, e_req);
            check("mem_we", mem_we, e_we);
            check("mem_addr", mem_addr, e_addr);
            check("mem_be", 32'(mem_be), 32'(e_be));
            check("mem_wdata", mem_wdata, e_wd);
        end
    end

    task automatic observe(input int j);
        if (mem_req) begin
            if (seen_req_cyc == 0) begin
                seen_we = mem_we; seen_addr = mem_addr; seen_be = mem_be; seen_wd = mem_wdata;
            end
            seen_req_cyc++;
        end
        if (done) begin
            seen_done_cnt++; seen_done_edge = j;
            seen_err = err; seen_rdata = rdata; seen_rd_we = rd_we;
        end
    endtask

    task automatic drive_noise(input logic keep);
        int r;
        r = $urandom_range(0, 2);
        start = keep;
        uop   = (r == 0) ? UOP_LDR : (r == 1) ? UOP_STR : UOP_ADD;
        size  = 2'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    // One core request; ack_d is the edge carrying mem_ack (beyond MW means never).
    task automatic run_txn(input logic st, input logic [4:0] u, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input int ack_d,
                           input logic [31:0] rd, input logic keep);
        logic acc, mis, is_ld, tmo;
        logic [31:0] r_addr, r_wd;
        logic [3:0]  r_be;
        int k;
        acc   = st && (u == UOP_LDR || u == UOP_STR);
        is_ld = (u == UOP_LDR);
        mis   = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        mis = acc && m_misaligned(sz, a);
`endif
        seen_req_cyc = 0; seen_done_cnt = 0; seen_done_edge = -1;
        start = st; uop = u; size = sz; addr = a; wdata = wd;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        @(posedge clk); #1;
        if (!acc) begin
            set_idle(); observe(0);
            start = 0; mem_ack = 0;
            return;
        end
        if (mis) begin
            set_done(1'b1, 1'b0, 32'h0); observe(0);
            drive_noise(keep); mem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            set_idle(); observe(1);
            start = 0; mem_ack = 0;
            return;
        end
        tmo    = (ack_d > MW);
        k      = tmo ? MW : ack_d;
        r_addr = a & 32'hFFFF_FFFC;
        r_be   = m_be(sz, a[1:0]);
        r_wd   = is_ld ? 32'h0 : m_wdata(sz, wd);
        set_req(!is_ld, r_addr, r_be, r_wd); observe(0);
        for (int j = 1; j <= k; j++) begin
            drive_noise(keep);
            mem_ack   = (j == ack_d);
            mem_rdata = (j == ack_d) ? rd : $urandom;
            @(posedge clk); #1;
            if (j < k) set_req(!is_ld, r_addr, r_be, r_wd);
            else set_done(tmo, is_ld && !tmo, (is_ld && !tmo) ? m_rdata(sz, a[1:0], rd) : 32'h0);
            observe(j);
        end
        drive_noise(keep); mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        @(posedge clk); #1;
        set_idle(); observe(k + 1);
        start = 0; mem_ack = 0;
    endtask

    initial begin
        int dcnt;
        rst = 1; start = 0; uop = 0; size = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
        set_idle();
        @(posedge clk); #1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_mem_be", 32'(mem_be), 0);
        rst = 0;
        @(posedge clk); #1;

        // LDR word, ack three cycles after request.
        run_txn(1, UOP_LDR, 2'd2, 32'h100, 32'h1234_5678, 3, 32'hDEAD_BEEF, 0);
        check("t1_addr", seen_addr, 32'h100);
        check("t1_be", 32'(seen_be), 32'hF);
        check("t1_rdata", seen_rdata, 32'hDEAD_BEEF);
        check("t1_rd_we", seen_rd_we, 1);
        check("t1_err", seen_err, 0);
        check("t1_done_edge", seen_done_edge, 3);

        // STR byte, immediate ack.
        run_txn(1, UOP_STR, 2'd0, 32'h203, 32'h0000_00A5, 1, 32'h0, 0);
        check("t2_we", seen_we, 1);
        check("t2_addr", seen_addr, 32'h200);
        check("t2_be", 32'(seen_be), 32'h8);
        check("t2_wdata", seen_wd, 32'hA5A5_A5A5);
        check("t2_done_edge", seen_done_edge, 1);
        check("t2_rd_we", seen_rd_we, 0);

        // LDR half from the upper halfword.
        run_txn(1, UOP_LDR, 2'd1, 32'h12, 32'h0, 2, 32'h8001_7FFF, 0);
        check("t3_be", 32'(seen_be), 32'hC);
        check("t3_rdata", seen_rdata, 32'h0000_8001);

        // No ack: abort after MAX_WAIT request cycles.
        run_txn(1, UOP_LDR, 2'd2, 32'h400, 32'h0, MW + 1, 32'h0, 0);
        check("t4_req_cycles", seen_req_cyc, MW);
        check("t4_err", seen_err, 1);
        check("t4_rd_we", seen_rd_we, 0);
        check("t4_rdata", seen_rdata, 0);
        check("t4_done_edge", seen_done_edge, MW);

        // Non-memory uop is ignored; start held high while busy is ignored.
        run_txn(1, UOP_ADD, 2'd2, 32'h40, 32'h0, 1, 32'h0, 0);
        check("t5_add_req", seen_req_cyc, 0);
        check("t5_add_done", seen_done_cnt, 0);
        run_txn(1, UOP_LDR, 2'd2, 32'h80, 32'h0, 2, 32'hCAFE_F00D, 1);
        check("t5_done_count", seen_done_cnt, 1);

        // Reset in the middle of a request.
        start = 1; uop = UOP_LDR; size = 2'd2; addr = 32'h300; mem_ack = 0;
        @(posedge clk); #1;
        set_req(1'b0, 32'h300, 4'hF, 32'h0);
        start = 0;
        @(posedge clk); #1;
        check("t6_req_before_rst", mem_req, 1);
        #2;
        rst = 1;
        set_idle();
        #1;
        check("t6_rst_mem_req", mem_req, 0);
        check("t6_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 0;
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        mem_ack = 0;
        check("t6_no_done", dcnt, 0);

`ifdef LSU_ALIGN_CHECK_EN
        // Misaligned word load aborts without a bus request.
        run_txn(1, UOP_LDR, 2'd2, 32'h102, 32'h0, 1, 32'h1111_2222, 0);
        check("t7_req_cycles", seen_req_cyc, 0);
        check("t7_done_edge", seen_done_edge, 0);
        check("t7_err", seen_err, 1);
        check("t7_rd_we", seen_rd_we, 0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            int r;
            logic [4:0] u;
            r = $urandom_range(0, 9);
            u = (r < 4) ? UOP_LDR : (r < 8) ? UOP_STR : 5'($urandom);
            run_txn(($urandom_range(0, 9) != 0), u, 2'($urandom), $urandom, $urandom,
                    $urandom_range(1, MW + 1), $urandom, 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
